// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM encoding, parity types, prescales.
// Used by uart_rx and its testbench.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

endpackage

// File: rtl/rx_data_sampler.sv
// Mid-bit sample point and bit-end detection for the UART receiver.
// UART_RX_MAJORITY_EN selects a 2-of-3 vote around the mid-bit point.
module rx_data_sampler (
`ifdef UART_RX_MAJORITY_EN
    input  logic       CLK,
    input  logic       Reset,
`endif
    input  logic       rx_i,
    input  logic [5:0] prescale_i,
    input  logic [5:0] edge_cnt_i,
    output logic       sampled_bit_o,
    output logic       sample_strobe_o,
    output logic       last_edge_o
);

    logic [5:0] half;

    assign half        = {1'b0, prescale_i[5:1]};
    assign last_edge_o = (edge_cnt_i == prescale_i - 6'd1);

`ifdef UART_RX_MAJORITY_EN
    logic s0_q;
    logic s1_q;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            s0_q <= 1'b1;
            s1_q <= 1'b1;
        end else begin
            if (edge_cnt_i == half - 6'd1) s0_q <= rx_i;
            if (edge_cnt_i == half)        s1_q <= rx_i;
        end
    end

    // Third vote is the live line one cycle past mid-bit.
    assign sample_strobe_o = (edge_cnt_i == half + 6'd1);
    assign sampled_bit_o   = (s0_q & s1_q) | (s0_q & rx_i) | (s1_q & rx_i);
`else
    assign sample_strobe_o = (edge_cnt_i == half);
    assign sampled_bit_o   = rx_i;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/parity/stop FSM with one-cycle result pulses.
// Define UART_RX_MAJORITY_EN for 3-sample majority voting per bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             RX_IN,
    input  logic [5:0]       Prescale,
    input  logic             Parity_EN,
    input  logic             Parity_type,
    output logic [width-1:0] P_DATA,
    output logic             Data_valid,
    output logic             Parity_error,
    output logic             Stop_error
);

    localparam int BW = (width > 1) ? $clog2(width) : 1;

    logic [2:0]       state_q, state_d;
    logic [5:0]       edge_q, edge_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [width-1:0] shift_q, shift_d;
    logic [width-1:0] pdata_q, pdata_d;
    logic [5:0]       presc_q, presc_d;
    logic             pen_q, pen_d;
    logic             ptype_q, ptype_d;
    logic             par_err_q, par_err_d;
    logic             stop_bit_q, stop_bit_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;
    logic             serr_q, serr_d;

    logic smp_bit;
    logic smp_stb;
    logic last_edge;
    logic exp_par;

    rx_data_sampler u_sampler (
`ifdef UART_RX_MAJORITY_EN
        .CLK            (CLK),
        .Reset          (Reset),
`endif
        .rx_i           (RX_IN),
        .prescale_i     (presc_q),
        .edge_cnt_i     (edge_q),
        .sampled_bit_o  (smp_bit),
        .sample_strobe_o(smp_stb),
        .last_edge_o    (last_edge)
    );

    assign exp_par = (ptype_q == PARITY_ODD) ? ~(^shift_q) : (^shift_q);

    always_comb begin
        state_d    = state_q;
        edge_d     = edge_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        pdata_d    = pdata_q;
        presc_d    = presc_q;
        pen_d      = pen_q;
        ptype_d    = ptype_q;
        par_err_d  = par_err_q;
        stop_bit_d = stop_bit_q;
        valid_d    = 1'b0;
        perr_d     = 1'b0;
        serr_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // The detecting cycle is edge 0 of the start bit.
                if (!RX_IN) begin
                    state_d   = ST_START;
                    edge_d    = 6'd1;
                    bit_d     = '0;
                    presc_d   = Prescale;
                    pen_d     = Parity_EN;
                    ptype_d   = Parity_type;
                    par_err_d = 1'b0;
                end
            end
            ST_START: begin
                edge_d = edge_q + 6'd1;
                if (smp_stb && smp_bit) begin
                    state_d = ST_IDLE;
                    edge_d  = '0;
                end else if (last_edge) begin
                    state_d = ST_DATA;
                    edge_d  = '0;
                end
            end
            ST_DATA: begin
                edge_d = edge_q + 6'd1;
                if (smp_stb) shift_d = {smp_bit, shift_q[width-1:1]};
                if (last_edge) begin
                    edge_d = '0;
                    if (bit_q == BW'(width - 1)) begin
                        bit_d   = '0;
                        state_d = pen_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                edge_d = edge_q + 6'd1;
                if (smp_stb) par_err_d = (smp_bit != exp_par);
                if (last_edge) begin
                    state_d = ST_STOP;
                    edge_d  = '0;
                end
            end
            ST_STOP: begin
                edge_d = edge_q + 6'd1;
                if (smp_stb) stop_bit_d = smp_bit;
                if (last_edge) begin
                    state_d = ST_IDLE;
                    edge_d  = '0;
                    valid_d = stop_bit_q && !par_err_q;
                    perr_d  = par_err_q;
                    serr_d  = !stop_bit_q;
                    if (stop_bit_q && !par_err_q) pdata_d = shift_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                edge_d  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q    <= ST_IDLE;
            edge_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            pdata_q    <= '0;
            presc_q    <= '0;
            pen_q      <= 1'b0;
            ptype_q    <= PARITY_EVEN;
            par_err_q  <= 1'b0;
            stop_bit_q <= 1'b1;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_q     <= edge_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            pdata_q    <= pdata_d;
            presc_q    <= presc_d;
            pen_q      <= pen_d;
            ptype_q    <= ptype_d;
            par_err_q  <= par_err_d;
            stop_bit_q <= stop_bit_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            serr_q     <= serr_d;
        end
    end

    assign P_DATA       = pdata_q;
    assign Data_valid   = valid_q;
    assign Parity_error = perr_q;
    assign Stop_error   = serr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx.
// Glitch injection on sample points is active with UART_RX_MAJORITY_EN.
module tb_uart_rx;
    import uart_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [5:0] presc;
    logic       pen;
    logic       ptype;
    logic [7:0] pdata;
    logic       dv;
    logic       pe;
    logic       se;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int         vcnt;
    int         pecnt;
    int         secnt;
    int         vcyc[$];
    logic [7:0] vdat[$];
    int         pecyc;
    int         secyc;

    uart_rx #(.width(8)) dut (
        .CLK         (clk),
        .Reset       (rst_n),
        .RX_IN       (rx),
        .Prescale    (presc),
        .Parity_EN   (pen),
        .Parity_type (ptype),
        .P_DATA      (pdata),
        .Data_valid  (dv),
        .Parity_error(pe),
        .Stop_error  (se)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dv) begin
            vcnt++;
            vcyc.push_back(cyc);
            vdat.push_back(pdata);
        end
        if (pe) begin
            pecnt++;
            pecyc = cyc;
        end
        if (se) begin
            secnt++;
            secyc = cyc;
        end
    end

    task automatic clr_mon();
        vcnt  = 0;
        pecnt = 0;
        secnt = 0;
        pecyc = -1;
        secyc = -1;
        vcyc.delete();
        vdat.delete();
    endtask

    // Drives one frame, one bit per p cycles, starting at a negedge.
    task automatic send_frame(input logic [7:0] d, input int p,
                              input bit with_par, input bit pbit,
                              input bit stopb, input bit glitch,
                              output int start_cyc);
        logic bits[0:10];
        int   n;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        bits[9]  = with_par ? pbit : stopb;
        bits[10] = stopb;
        n = with_par ? 11 : 10;
        start_cyc = cyc;
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < p; c++) begin
                rx = (glitch && c == p / 2) ? ~bits[b] : bits[b];
                @(negedge clk);
            end
        end
        rx = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx    = 1'b1;
        presc = PRESCALE_8;
        pen   = 1'b0;
        ptype = PARITY_EVEN;
        repeat (3) @(negedge clk);
        checks++;
        if (pdata !== 8'h00) begin
            failures++;
            $display("FAIL reset_pdata got=%h exp=00", pdata);
        end
        checks++;
        if ({dv, pe, se} !== 3'b000) begin
            failures++;
            $display("FAIL reset_pulses got=%b exp=000", {dv, pe, se});
        end
        checks++;
        if (dut.state_q !== ST_IDLE) begin
            failures++;
            $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, ST_IDLE);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_even_p8();
        int st;
        clr_mon();
        presc = PRESCALE_8;
        pen   = 1'b1;
        ptype = PARITY_EVEN;
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b0, st);
        repeat (20) @(negedge clk);
        checks++;
        if (vcnt !== 1) begin
            failures++;
            $display("FAIL even_p8_vcnt got=%0d exp=1", vcnt);
        end
        checks++;
        if (vcnt >= 1 && vdat[0] !== 8'hA5) begin
            failures++;
            $display("FAIL even_p8_data got=%h exp=a5", vdat[0]);
        end
        checks++;
        if (vcnt >= 1 && vcyc[0] - st !== 88) begin
            failures++;
            $display("FAIL even_p8_latency got=%0d exp=88", vcyc[0] - st);
        end
        checks++;
        if (pecnt + secnt !== 0) begin
            failures++;
            $display("FAIL even_p8_errs got=%0d exp=0", pecnt + secnt);
        end
    endtask

    task automatic test_parity_err_p16();
        int st;
        clr_mon();
        presc = PRESCALE_16;
        pen   = 1'b1;
        ptype = PARITY_ODD;
        // 0x3C has four ones, so odd parity is 1; send 0.
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b0, st);
        repeat (20) @(negedge clk);
        checks++;
        if (pecnt !== 1 || pecyc - st !== 176) begin
            failures++;
            $display("FAIL perr_pulse got=%0d@%0d exp=1@176", pecnt, pecyc - st);
        end
        checks++;
        if (vcnt !== 0 || secnt !== 0) begin
            failures++;
            $display("FAIL perr_others got=v%0d s%0d exp=v0 s0", vcnt, secnt);
        end
        checks++;
        if (pdata !== 8'hA5) begin
            failures++;
            $display("FAIL perr_hold got=%h exp=a5", pdata);
        end
    endtask

    task automatic test_stop_err_p32();
        int st;
        clr_mon();
        presc = PRESCALE_32;
        pen   = 1'b0;
        ptype = PARITY_EVEN;
        send_frame(8'hFF, 32, 1'b0, 1'b0, 1'b0, 1'b0, st);
        checks++;
        if (dut.state_q !== ST_IDLE || !se) begin
            failures++;
            $display("FAIL serr_pulse_idle got=st%0d se%b exp=st0 se1",
                     dut.state_q, se);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (secnt !== 1 || secyc - st !== 320) begin
            failures++;
            $display("FAIL serr_pulse got=%0d@%0d exp=1@320", secnt, secyc - st);
        end
        checks++;
        if (vcnt !== 0 || pecnt !== 0 || pdata !== 8'hA5) begin
            failures++;
            $display("FAIL serr_others got=v%0d p%0d d%h exp=v0 p0 da5",
                     vcnt, pecnt, pdata);
        end
    endtask

    task automatic test_glitch_p16();
        clr_mon();
        presc = PRESCALE_16;
        pen   = 1'b0;
        rx    = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (dut.state_q !== ST_START) begin
            failures++;
            $display("FAIL glitch_start got=%0d exp=%0d", dut.state_q, ST_START);
        end
        @(negedge clk);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (dut.state_q !== ST_IDLE) begin
            failures++;
            $display("FAIL glitch_idle got=%0d exp=%0d", dut.state_q, ST_IDLE);
        end
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (vcnt + pecnt + secnt !== 0 || dut.state_q !== ST_IDLE) begin
            failures++;
            $display("FAIL glitch_quiet got=pulses%0d st%0d exp=pulses0 st0",
                     vcnt + pecnt + secnt, dut.state_q);
        end
    endtask

    task automatic test_reset_midframe();
        logic [9:0] fr;
        int         st;
        clr_mon();
        presc = PRESCALE_8;
        pen   = 1'b0;
        fr    = {1'b1, 8'h81, 1'b0};
        for (int b = 0; b < 5; b++) begin
            for (int c = 0; c < 8; c++) begin
                rx = fr[b];
                @(negedge clk);
            end
        end
        rx = fr[5];
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({dv, pe, se} !== 3'b000 || pdata !== 8'h00) begin
            failures++;
            $display("FAIL rst_mid_outs got=%b/%h exp=000/00", {dv, pe, se}, pdata);
        end
        checks++;
        if (dut.state_q !== ST_IDLE || dut.edge_q !== 6'd0 || dut.bit_q !== 3'd0) begin
            failures++;
            $display("FAIL rst_mid_fsm got=st%0d e%0d b%0d exp=0/0/0",
                     dut.state_q, dut.edge_q, dut.bit_q);
        end
        @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, 1'b0, st);
        repeat (20) @(negedge clk);
        checks++;
        if (vcnt !== 1 || (vcnt >= 1 && (vdat[0] !== 8'h81 || vcyc[0] - st !== 80))) begin
            failures++;
            $display("FAIL rst_mid_frame got=n%0d d%h exp=n1 d81 @80", vcnt,
                     (vcnt >= 1) ? vdat[0] : 8'hxx);
        end
        checks++;
        if (pecnt + secnt !== 0) begin
            failures++;
            $display("FAIL rst_mid_errs got=%0d exp=0", pecnt + secnt);
        end
    endtask

    task automatic test_back_to_back();
        int  st0;
        int  st1;
        bit  g;
`ifdef UART_RX_MAJORITY_EN
        g = 1'b1;
`else
        g = 1'b0;
`endif
        clr_mon();
        presc = PRESCALE_16;
        pen   = 1'b1;
        ptype = PARITY_EVEN;
        send_frame(8'h12, 16, 1'b1, 1'b0, 1'b1, g, st0);
        send_frame(8'h34, 16, 1'b1, 1'b1, 1'b1, g, st1);
        repeat (30) @(negedge clk);
        checks++;
        if (vcnt !== 2) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=2", vcnt);
        end
        checks++;
        if (vcnt == 2 && (vdat[0] !== 8'h12 || vdat[1] !== 8'h34)) begin
            failures++;
            $display("FAIL b2b_data got=%h,%h exp=12,34", vdat[0], vdat[1]);
        end
        checks++;
        if (vcnt == 2 && (vcyc[0] - st0 !== 176 || vcyc[1] - vcyc[0] !== 176)) begin
            failures++;
            $display("FAIL b2b_timing got=%0d,%0d exp=176,176",
                     vcyc[0] - st0, vcyc[1] - vcyc[0]);
        end
        checks++;
        if (pecnt + secnt !== 0 || pdata !== 8'h34) begin
            failures++;
            $display("FAIL b2b_final got=e%0d d%h exp=e0 d34", pecnt + secnt, pdata);
        end
    endtask

    initial begin
        test_reset();
        test_even_p8();
        test_parity_err_p16();
        test_stop_err_p32();
        test_glitch_p16();
        test_reset_midframe();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
